// File: rtl/mgt_01_f_scoreboard_reg_file_pkg.sv
// Shared types and default sizes for the floating-point register file and scoreboard.
package mgt_01_f_scoreboard_reg_file_pkg;

  localparam int unsigned FLEN     = 32;
  localparam int unsigned N_F_REGS = 32;
  localparam int unsigned N_READ   = 3;
  localparam int unsigned N_WRITE  = 2;

  typedef logic [FLEN-1:0] float_t;

  // Architectural floating-point register names.
  typedef enum logic [4:0] {
    RegF0,  RegF1,  RegF2,  RegF3,  RegF4,  RegF5,  RegF6,  RegF7,
    RegF8,  RegF9,  RegF10, RegF11, RegF12, RegF13, RegF14, RegF15,
    RegF16, RegF17, RegF18, RegF19, RegF20, RegF21, RegF22, RegF23,
    RegF24, RegF25, RegF26, RegF27, RegF28, RegF29, RegF30, RegF31
  } f_register_e;

endpackage

// File: rtl/mgt_01_f_scoreboard.sv
// Scoreboard of pending destination registers: reservation set, writeback clear,
// set-over-clear priority and issue acceptance.
module mgt_01_f_scoreboard
  import mgt_01_f_scoreboard_reg_file_pkg::*;
#(
  parameter int unsigned N_REGS = N_F_REGS,
  localparam int unsigned AW    = $clog2(N_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic [N_REGS-1:0] clr_i,       // registers written this cycle, already gated by clk_en_i
  output logic              iss_ready_o,
  output logic [N_REGS-1:0] busy_o
);

  logic [N_REGS-1:0] busy_q, busy_d;
  logic              set_en;

  // A busy destination may be re-reserved when its pending write lands this cycle (WAW).
  always_comb begin
    iss_ready_o = ~busy_q[iss_addr_i] | clr_i[iss_addr_i];
    set_en      = clk_en_i & iss_valid_i & iss_ready_o;
  end

  // Next scoreboard: clear written registers first so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (clk_en_i) begin
      busy_d = busy_q & ~clr_i;
      if (set_en) begin
        busy_d[iss_addr_i] = 1'b1;
      end
    end
  end

  // Scoreboard state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/mgt_01_f_scoreboard_reg_file.sv
// Multi-ported floating-point register file with write-to-read bypass and a
// destination scoreboard for operand readiness.
module mgt_01_f_scoreboard_reg_file
  import mgt_01_f_scoreboard_reg_file_pkg::*;
#(
  parameter int unsigned FLEN    = mgt_01_f_scoreboard_reg_file_pkg::FLEN,
  parameter int unsigned N_REGS  = mgt_01_f_scoreboard_reg_file_pkg::N_F_REGS,
  parameter int unsigned N_READ  = mgt_01_f_scoreboard_reg_file_pkg::N_READ,
  parameter int unsigned N_WRITE = mgt_01_f_scoreboard_reg_file_pkg::N_WRITE,
  localparam int unsigned AW     = $clog2(N_REGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic [N_READ*AW-1:0]    rd_addr_i,
  output logic [N_READ*FLEN-1:0]  rd_data_o,
  output logic [N_READ-1:0]       rd_valid_o,
  input  logic [N_WRITE-1:0]      wr_en_i,
  input  logic [N_WRITE*AW-1:0]   wr_addr_i,
  input  logic [N_WRITE*FLEN-1:0] wr_data_i,
  input  logic                    iss_valid_i,
  input  logic [AW-1:0]           iss_addr_i,
  output logic                    iss_ready_o,
  output logic [N_REGS-1:0]       busy_o
);

  logic [FLEN-1:0]   regs_q [N_REGS];
  logic [FLEN-1:0]   regs_d [N_REGS];
  logic [N_WRITE-1:0] wr_act;
  logic [N_REGS-1:0] wr_hit;
  logic [AW-1:0]     wr_addr [N_WRITE];
  logic [FLEN-1:0]   wr_data [N_WRITE];

  // Unpack write ports and qualify them with the clock enable.
  always_comb begin
    wr_hit = '0;
    for (int unsigned k = 0; k < N_WRITE; k++) begin
      wr_addr[k] = wr_addr_i[k*AW +: AW];
      wr_data[k] = wr_data_i[k*FLEN +: FLEN];
      wr_act[k]  = clk_en_i & wr_en_i[k];
      if (wr_act[k]) begin
        wr_hit[wr_addr[k]] = 1'b1;
      end
    end
  end

  // Next register contents; ascending port order lets the highest port win.
  always_comb begin
    for (int unsigned a = 0; a < N_REGS; a++) begin
      regs_d[a] = regs_q[a];
    end
    for (int unsigned k = 0; k < N_WRITE; k++) begin
      if (wr_act[k]) begin
        regs_d[wr_addr[k]] = wr_data[k];
      end
    end
  end

  // Register storage with synchronous reset to +0.0.
  always_ff @(posedge clk_i) begin
    for (int unsigned a = 0; a < N_REGS; a++) begin
      if (rst_i) begin
        regs_q[a] <= '0;
      end else begin
        regs_q[a] <= regs_d[a];
      end
    end
  end

  mgt_01_f_scoreboard #(
    .N_REGS (N_REGS)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clk_en_i    (clk_en_i),
    .iss_valid_i (iss_valid_i),
    .iss_addr_i  (iss_addr_i),
    .clr_i       (wr_hit),
    .iss_ready_o (iss_ready_o),
    .busy_o      (busy_o)
  );

  // Combinational reads with same-cycle write bypass (highest port wins).
  always_comb begin
    rd_data_o  = '0;
    rd_valid_o = '0;
    for (int unsigned r = 0; r < N_READ; r++) begin
      logic [AW-1:0] ra;
      ra = rd_addr_i[r*AW +: AW];
      rd_data_o[r*FLEN +: FLEN] = regs_q[ra];
      rd_valid_o[r]             = ~busy_o[ra];
      for (int unsigned k = 0; k < N_WRITE; k++) begin
        if (wr_act[k] && (wr_addr[k] == ra)) begin
          rd_data_o[r*FLEN +: FLEN] = wr_data[k];
          rd_valid_o[r]             = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mgt_01_f_scoreboard_reg_file.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural register-file/scoreboard model.
module tb_mgt_01_f_scoreboard_reg_file;

  localparam int FLEN    = 32;
  localparam int NREGS   = 32;
  localparam int NREAD   = 3;
  localparam int NWRITE  = 2;
  localparam int AW      = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, clk_en, iss_valid, iss_ready;
  logic [AW-1:0]           iss_addr;
  logic [NWRITE-1:0]       wr_en;
  logic [AW-1:0]           rd_addr_a [NREAD];
  logic [AW-1:0]           wr_addr_a [NWRITE];
  logic [FLEN-1:0]         wr_data_a [NWRITE];
  logic [NREAD*AW-1:0]     rd_addr_f;
  logic [NWRITE*AW-1:0]    wr_addr_f;
  logic [NWRITE*FLEN-1:0]  wr_data_f;
  logic [NREAD*FLEN-1:0]   rd_data_f;
  logic [NREAD-1:0]        rd_valid;
  logic [NREGS-1:0]        busy;

  always_comb begin
    for (int i = 0; i < NREAD; i++) rd_addr_f[i*AW +: AW] = rd_addr_a[i];
    for (int i = 0; i < NWRITE; i++) begin
      wr_addr_f[i*AW +: AW]     = wr_addr_a[i];
      wr_data_f[i*FLEN +: FLEN] = wr_data_a[i];
    end
  end

  mgt_01_f_scoreboard_reg_file dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clk_en_i    (clk_en),
    .rd_addr_i   (rd_addr_f),
    .rd_data_o   (rd_data_f),
    .rd_valid_o  (rd_valid),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr_f),
    .wr_data_i   (wr_data_f),
    .iss_valid_i (iss_valid),
    .iss_addr_i  (iss_addr),
    .iss_ready_o (iss_ready),
    .busy_o      (busy)
  );

  // Reference model state.
  logic [FLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit write_lands(input logic [AW-1:0] a);
    bit hit = 0;
    if (clk_en) for (int w = 0; w < NWRITE; w++) if (wr_en[w] && wr_addr_a[w] == a) hit = 1;
    return hit;
  endfunction

  function automatic bit exp_ready();
    return !m_busy[iss_addr] || write_lands(iss_addr);
  endfunction

  // Compare every output with what the model predicts for the current inputs.
  task automatic check_model();
    logic [NREGS-1:0] eb;
    for (int r = 0; r < NREAD; r++) begin
      logic [FLEN-1:0] ed;
      bit ev, found;
      ed = m_regs[rd_addr_a[r]];
      ev = !m_busy[rd_addr_a[r]];
      found = 0;
      if (clk_en) begin
        for (int w = NWRITE - 1; w >= 0; w--) begin
          if (!found && wr_en[w] && wr_addr_a[w] == rd_addr_a[r]) begin
            ed = wr_data_a[w];
            ev = 1;
            found = 1;
          end
        end
      end
      chk($sformatf("rd_data%0d", r), rd_data_f[r*FLEN +: FLEN], ed);
      chk($sformatf("rd_valid%0d", r), 32'(rd_valid[r]), 32'(ev));
    end
    chk("iss_ready", 32'(iss_ready), 32'(exp_ready()));
    for (int a = 0; a < NREGS; a++) eb[a] = m_busy[a];
    chk("busy", busy, eb);
  endtask

  // Clock edge: update the model from the inputs held across this edge.
  task automatic advance();
    logic [FLEN-1:0] nregs [NREGS];
    bit              nbusy [NREGS];
    bit              rdy;
    rdy = exp_ready();
    for (int a = 0; a < NREGS; a++) begin
      nregs[a] = m_regs[a];
      nbusy[a] = m_busy[a];
    end
    if (rst) begin
      for (int a = 0; a < NREGS; a++) begin
        nregs[a] = '0;
        nbusy[a] = 0;
      end
    end else if (clk_en) begin
      for (int a = 0; a < NREGS; a++) begin
        bit done = 0;
        for (int w = NWRITE - 1; w >= 0; w--) begin
          if (!done && wr_en[w] && wr_addr_a[w] == a) begin
            nregs[a] = wr_data_a[w];
            nbusy[a] = 0;
            done = 1;
          end
        end
      end
      if (iss_valid && rdy) nbusy[iss_addr] = 1;
    end
    @(posedge clk);
    #1;
    for (int a = 0; a < NREGS; a++) begin
      m_regs[a] = nregs[a];
      m_busy[a] = nbusy[a];
    end
  endtask

  task automatic settle_check();
    #2;
    check_model();
  endtask

  task automatic idle();
    rst = 0; clk_en = 1; iss_valid = 0; iss_addr = '0; wr_en = '0;
    for (int i = 0; i < NWRITE; i++) begin
      wr_addr_a[i] = '0;
      wr_data_a[i] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < NREAD; i++) rd_addr_a[i] = '0;
    idle();
    for (int a = 0; a < NREGS; a++) begin
      m_regs[a] = '0;
      m_busy[a] = 0;
    end
    // Reset from unknown state; no comparison before it takes effect.
    rst = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 0;

    // Reset view of every register.
    for (int base = 0; base < NREGS; base += NREAD) begin
      for (int i = 0; i < NREAD; i++) rd_addr_a[i] = AW'((base + i) % NREGS);
      settle_check();
      advance();
    end
    chk("reset_busy", busy, 32'h0);
    chk("reset_ready", 32'(iss_ready), 32'h1);

    // Issue f5, then resolve it through a port-1 write with bypass.
    iss_valid = 1; iss_addr = 5;
    settle_check();
    advance();
    iss_valid = 0; rd_addr_a[0] = 5;
    settle_check();
    chk("f5_pending_valid", 32'(rd_valid[0]), 32'h0);
    chk("f5_pending_ready", 32'(iss_ready), 32'h0);
    advance();
    wr_en = 2'b10; wr_addr_a[1] = 5; wr_data_a[1] = 32'h3F80_0000;
    settle_check();
    chk("f5_bypass_data", rd_data_f[FLEN-1:0], 32'h3F80_0000);
    chk("f5_bypass_valid", 32'(rd_valid[0]), 32'h1);
    advance();
    idle();
    settle_check();
    chk("f5_cleared", 32'(busy[5]), 32'h0);
    advance();

    // Both ports write f7: port 1 wins, in bypass and in storage.
    wr_en = 2'b11; wr_addr_a[0] = 7; wr_addr_a[1] = 7;
    wr_data_a[0] = 32'h4000_0000; wr_data_a[1] = 32'h4040_0000; rd_addr_a[0] = 7;
    settle_check();
    chk("f7_bypass", rd_data_f[FLEN-1:0], 32'h4040_0000);
    advance();
    idle();
    settle_check();
    chk("f7_stored", rd_data_f[FLEN-1:0], 32'h4040_0000);
    advance();

    // WAW on f9: re-issue during the pending write; set beats clear.
    iss_valid = 1; iss_addr = 9;
    settle_check();
    advance();
    wr_en = 2'b01; wr_addr_a[0] = 9; wr_data_a[0] = 32'hCAFE_F00D;
    settle_check();
    chk("f9_waw_ready", 32'(iss_ready), 32'h1);
    advance();
    idle(); rd_addr_a[0] = 9;
    settle_check();
    chk("f9_still_busy", 32'(busy[9]), 32'h1);
    chk("f9_data", rd_data_f[FLEN-1:0], 32'hCAFE_F00D);
    advance();

    // Clock enable low: no write, no bypass, no reservation.
    clk_en = 0; wr_en = 2'b01; wr_addr_a[0] = 3; wr_data_a[0] = 32'h1234_5678;
    iss_valid = 1; iss_addr = 4; rd_addr_a[0] = 3;
    settle_check();
    chk("cken0_no_bypass", rd_data_f[FLEN-1:0], 32'h0);
    advance();
    idle(); rd_addr_a[0] = 3;
    settle_check();
    chk("cken0_f3", rd_data_f[FLEN-1:0], 32'h0);
    chk("cken0_busy4", 32'(busy[4]), 32'h0);
    advance();

    // Reset mid-operation discards reservations and same-cycle writes.
    iss_valid = 1; iss_addr = 4;
    settle_check();
    advance();
    rst = 1; wr_en = 2'b11; wr_addr_a[0] = 10; wr_addr_a[1] = 3;
    wr_data_a[0] = 32'h0000_0055; wr_data_a[1] = 32'hAAAA_AAAA; iss_addr = 11;
    settle_check();
    advance();
    idle(); rd_addr_a[0] = 10; rd_addr_a[1] = 3; rd_addr_a[2] = 7;
    settle_check();
    chk("rst_busy", busy, 32'h0);
    chk("rst_f10", rd_data_f[FLEN-1:0], 32'h0);
    chk("rst_f7", rd_data_f[3*FLEN-1:2*FLEN], 32'h0);
    advance();

    // Randomized traffic on a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      clk_en    = ($urandom_range(0, 9) != 0);
      iss_valid = $urandom_range(0, 1);
      iss_addr  = AW'($urandom_range(0, 7));
      wr_en     = NWRITE'($urandom);
      for (int i = 0; i < NWRITE; i++) begin
        wr_addr_a[i] = AW'($urandom_range(0, 7));
        wr_data_a[i] = $urandom;
      end
      for (int i = 0; i < NREAD; i++) rd_addr_a[i] = AW'($urandom_range(0, 9));
      settle_check();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mgt_01_f_scoreboard_reg_file.md
MGT_01_F_SCOREBOARD_REG_FILE -- requirements
Module: MGT_01_f_scoreboard_reg_file

Interface
REQ-001 The block SHALL use one clock, clk_i; reset rst_i SHALL be synchronous and active-high.
REQ-002 Parameter FLEN, 32, floating point data width in bits.
REQ-003 Parameter N_REGS, 32, number of floating point registers; AW = $clog2(N_REGS).
REQ-004 Parameter N_READ, 3, number of read ports.
REQ-005 Parameter N_WRITE, 2, number of write ports.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clk_en_i  in  1  global clock enable
- rd_addr_i  in  N_READ*AW  read addresses, port k in slice k
- rd_data_o  out  N_READ*FLEN  read data
- rd_valid_o  out  N_READ  operand not pending
- wr_en_i  in  N_WRITE  write enables
- wr_addr_i  in  N_WRITE*AW  write addresses
- wr_data_i  in  N_WRITE*FLEN  write data
- iss_valid_i  in  1  request to reserve a destination register
- iss_addr_i  in  AW  destination register to reserve
- iss_ready_o  out  1  reservation accepted this cycle
- busy_o  out  N_REGS  scoreboard bits

Function
REQ-007 Write port k SHALL update register wr_addr_i[k] at posedge clk_i when clk_en_i & wr_en_i[k]; there is no hardwired-zero register.
REQ-008 When several enabled write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-009 Reads SHALL be combinational, with zero latency.
REQ-010 Bypass: if clk_en_i=1 and an enabled write targets rd_addr_i[k] in the same cycle, rd_data_o[k] SHALL equal that write data (highest-index port wins) and rd_valid_o[k] SHALL be 1.
REQ-011 Without a bypass, rd_valid_o[k] SHALL equal ~busy[rd_addr_i[k]].
REQ-012 busy[a] SHALL be set at posedge when clk_en_i & iss_valid_i & iss_ready_o and iss_addr_i=a.
REQ-013 busy[a] SHALL be cleared at posedge when clk_en_i and any enabled write targets a.
REQ-014 When a set and a clear hit the same register in one cycle, the set SHALL win (busy stays 1).
REQ-015 iss_ready_o SHALL equal ~busy[iss_addr_i] | (clk_en_i & any enabled write to iss_addr_i), which resolves WAW hazards.
REQ-016 A write to a non-busy register SHALL be legal: data is written and busy stays 0.
REQ-017 With clk_en_i=0: no register or busy change, no bypass, and combinational reads SHALL remain active.
REQ-018 busy_o SHALL reflect the registered scoreboard with no bypass.

Reset
REQ-019 rst_i=1 at posedge SHALL clear all registers to 0 (+0.0) and all busy bits to 0, regardless of clk_en_i, writes or issue.
REQ-020 After reset the outputs SHALL be: rd_data_o all 0, rd_valid_o all 1, iss_ready_o 1, busy_o 0.
REQ-021 Reset asserted mid-operation SHALL discard all reservations and same-cycle writes.

Structure
REQ-022 f_register_e, float_t, FLEN and N_F_REGS SHALL reside in the shared package; parameter defaults SHALL come from it.
REQ-023 The busy array, with its set/clear/priority logic, SHALL be the single sub-module MGT_01_f_scoreboard; data storage and bypass SHALL stay in the top.

Verification
REQ-024 Reset, then read f0..f31 -> all data 0x00000000, rd_valid_o all 1, busy_o=0.
REQ-025 Issue f5; next cycle read f5 -> rd_valid=0 and iss_ready for f5 =0. Write 0x3F800000 via port 1 with f5 read same cycle -> rd_data=0x3F800000, rd_valid=1. Next cycle busy[5]=0.
REQ-026 Both ports write f7 (port0 0x40000000, port1 0x40400000) -> f7 reads 0x40400000 afterwards; the bypass during the write cycle also shows 0x40400000.
REQ-027 f9 busy; in one cycle write f9 and issue f9 -> iss_ready_o=1, data updated, busy[9] stays 1.
REQ-028 clk_en_i=0 with write f3=0x12345678 and issue f4 -> f3 unchanged, no bypass, busy[4]=0. Then rst_i with write pending -> all registers and busy cleared.
